xor_stream_encrypt: RTL and testbench

- Sits directly downstream of the key assembler.
- Captures the MSG_SIZE-bit assembled key when the assembler's done flag pulses.
- XOR-encrypts a stream of MSG_SIZE-bit message words against that key, rotating the key after every word.
- Delivers ciphertext through a valid/ready output register.
- The key expires after MAX_MSGS words; the block then returns to waiting for a fresh key.

---
 rtl/xor_stream_encrypt.sv | 158 +++++++++++++++
 tb/tb_xor_stream_encrypt.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_encrypt.sv
// XOR stream cipher stage: latches an assembled key, encrypts a word stream
// against a per-word rotating key, and retires the key after MAX_MSGS words.
module xor_stream_encrypt #(
  parameter int MSG_SIZE = 8,
  parameter int ROT      = 1,
  parameter int MAX_MSGS = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [MSG_SIZE-1:0] iKey_Assembled,
  input  logic                iAssembled,
  input  logic                iClear,
  input  logic [MSG_SIZE-1:0] iMsg,
  input  logic                iMsg_Valid,
  output logic                oMsg_Ready,
  output logic [MSG_SIZE-1:0] oCipher,
  output logic                oCipher_Valid,
  input  logic                iCipher_Ready,
  output logic                oKey_Loaded,
  output logic                oKey_Expired
);

  localparam int CW    = $clog2(MAX_MSGS + 1);
  localparam int ROT_M = ROT % MSG_SIZE;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_MSGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [MSG_SIZE-1:0] key_reg;
  logic [CW-1:0]       count;
  logic [MSG_SIZE-1:0] cipher_p1;
  logic                vld_p1;
  logic                expired_p1;

  logic accept;
  logic take;
  logic last_word;
  logic drain_done;
  logic ready;

  // Shift form collapses to k | k == k when ROT_M is zero.
  function automatic logic [MSG_SIZE-1:0] rotl(input logic [MSG_SIZE-1:0] k);
    return (k << ROT_M) | (k >> ((MSG_SIZE - ROT_M) % MSG_SIZE));
  endfunction

  function automatic logic [MSG_SIZE-1:0] encrypt(input logic [MSG_SIZE-1:0] m,
                                                  input logic [MSG_SIZE-1:0] k);
    return m ^ k;
  endfunction

  // An abort swallows any handshake that coincides with it.
  assign accept     = iMsg_Valid && ready && !iClear;
  assign take       = vld_p1 && iCipher_Ready;
  assign last_word  = accept && ((count + CW'(1)) == CNT_MAX);
  assign drain_done = (state == DRAIN) && (!vld_p1 || iCipher_Ready);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (iClear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (iAssembled) state_next = LOADED;
        LOADED:  if (iAssembled) state_next = LOADED;
                 else if (last_word) state_next = DRAIN;
        DRAIN:   if (drain_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready       = 1'b0;
    oKey_Loaded = 1'b0;
    if (state == LOADED) begin
      ready       = !vld_p1 || iCipher_Ready;
      oKey_Loaded = 1'b1;
    end
  end

  assign oMsg_Ready = ready;

  // A refresh outranks rotation: the word accepted alongside it still used the old key.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      key_reg <= '0;
      count   <= '0;
    end else if (iClear) begin
      key_reg <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iAssembled) begin
            key_reg <= iKey_Assembled;
            count   <= '0;
          end
        end
        LOADED: begin
          if (iAssembled) begin
            key_reg <= iKey_Assembled;
            count   <= '0;
          end else if (accept) begin
            key_reg <= rotl(key_reg);
            count   <= count + CW'(1);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            key_reg <= '0;
            count   <= '0;
          end
        end
        default: begin
          key_reg <= '0;
          count   <= '0;
        end
      endcase
    end
  end

  // Stage p1: ciphertext output register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cipher_p1 <= '0;
      vld_p1    <= 1'b0;
    end else if (iClear) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      cipher_p1 <= encrypt(iMsg, key_reg);
      vld_p1    <= 1'b1;
    end else if (take) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)        expired_p1 <= 1'b0;
    else if (iClear) expired_p1 <= 1'b0;
    else             expired_p1 <= drain_done;
  end

  assign oCipher       = cipher_p1;
  assign oCipher_Valid = vld_p1;
  assign oKey_Expired  = expired_p1;

endmodule

// File: tb/tb_xor_stream_encrypt.sv
// Directed bench for xor_stream_encrypt: default build, a 4-word-budget build
// and a static-key build share one stimulus bus.
module tb_xor_stream_encrypt;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_in;
  logic       assembled;
  logic       clear;
  logic [7:0] msg;
  logic       msg_valid;
  logic       cipher_ready;

  logic       a_ready, a_vld, a_loaded, a_expired;
  logic [7:0] a_cipher;
  logic       b_ready, b_vld, b_loaded, b_expired;
  logic [7:0] b_cipher;
  logic       c_ready, c_vld, c_loaded, c_expired;
  logic [7:0] c_cipher;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  xor_stream_encrypt #(.MSG_SIZE(8), .ROT(1), .MAX_MSGS(16)) dut_a (
    .iClk(clk), .iRst(rst), .iKey_Assembled(key_in), .iAssembled(assembled),
    .iClear(clear), .iMsg(msg), .iMsg_Valid(msg_valid), .oMsg_Ready(a_ready),
    .oCipher(a_cipher), .oCipher_Valid(a_vld), .iCipher_Ready(cipher_ready),
    .oKey_Loaded(a_loaded), .oKey_Expired(a_expired)
  );

  xor_stream_encrypt #(.MSG_SIZE(8), .ROT(1), .MAX_MSGS(4)) dut_b (
    .iClk(clk), .iRst(rst), .iKey_Assembled(key_in), .iAssembled(assembled),
    .iClear(clear), .iMsg(msg), .iMsg_Valid(msg_valid), .oMsg_Ready(b_ready),
    .oCipher(b_cipher), .oCipher_Valid(b_vld), .iCipher_Ready(cipher_ready),
    .oKey_Loaded(b_loaded), .oKey_Expired(b_expired)
  );

  xor_stream_encrypt #(.MSG_SIZE(8), .ROT(0), .MAX_MSGS(16)) dut_c (
    .iClk(clk), .iRst(rst), .iKey_Assembled(key_in), .iAssembled(assembled),
    .iClear(clear), .iMsg(msg), .iMsg_Valid(msg_valid), .oMsg_Ready(c_ready),
    .oCipher(c_cipher), .oCipher_Valid(c_vld), .iCipher_Ready(cipher_ready),
    .oKey_Loaded(c_loaded), .oKey_Expired(c_expired)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    assembled    = 1'b0;
    clear        = 1'b0;
    msg_valid    = 1'b0;
    cipher_ready = 1'b0;
    rst          = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic load_key(input logic [7:0] k);
    key_in    = k;
    assembled = 1'b1;
    tick();
    assembled = 1'b0;
  endtask

  function automatic logic [7:0] rotl1(input logic [7:0] k);
    return {k[6:0], k[7]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] mkey;
    logic [7:0] exp_ex[4];
    logic [7:0] sent_msg;
    logic       acc;
    int         sent;
    int         rcvd;

    rst = 1'b1; clear = 1'b0; assembled = 1'b0; key_in = '0;
    msg = '0; msg_valid = 1'b0; cipher_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cipher",  a_cipher,  8'h00);
    check("rst_vld",     a_vld,     1'b0);
    check("rst_loaded",  a_loaded,  1'b0);
    check("rst_expired", a_expired, 1'b0);
    check("rst_ready",   a_ready,   1'b0);
    rst = 1'b0;
    tick();

    // Basic path
    load_key(8'hA5);
    check("basic_loaded", a_loaded, 1'b1);
    msg = 8'h3C; msg_valid = 1'b1; cipher_ready = 1'b1;
    #1;
    check("basic_ready", a_ready, 1'b1);
    tick();
    check("basic_c0", a_cipher, 8'h99);
    check("basic_v0", a_vld, 1'b1);
    tick();
    check("basic_c1", a_cipher, 8'h77);
    msg_valid = 1'b0;
    tick();
    check("basic_vld_clr", a_vld, 1'b0);
    check("basic_loaded2", a_loaded, 1'b1);

    // Backpressure: one pending word held, then randomly stalled stream
    do_reset();
    load_key(8'hA5);
    msg = 8'h11; msg_valid = 1'b1; cipher_ready = 1'b0;
    tick();
    msg_valid = 1'b0;
    check("bp_first", a_cipher, 8'hB4);
    #1;
    check("bp_ready_low", a_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_vld", a_vld, 1'b1);
      check("bp_hold_data", a_cipher, 8'hB4);
    end
    q.push_back(8'hB4);
    mkey = 8'h4B;
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 300 && rcvd < 11; cyc++) begin
      cipher_ready = 1'($urandom_range(0, 1));
      msg_valid    = (sent < 10);
      msg          = 8'(sent * 37 + 5);
      #1;
      acc      = msg_valid && a_ready;
      sent_msg = msg;
      if (a_vld && cipher_ready) begin
        check("bp_data", a_cipher, q.pop_front());
        rcvd++;
      end
      tick();
      if (acc) begin
        q.push_back(sent_msg ^ mkey);
        mkey = rotl1(mkey);
        sent++;
      end
    end
    check("bp_count", 8'(rcvd), 8'd11);
    msg_valid = 1'b0; cipher_ready = 1'b1;
    tick();

    // Expiry on the 4-word build
    do_reset();
    load_key(8'h0F);
    exp_ex = '{8'h0F, 8'h1E, 8'h3C, 8'h78};
    msg = 8'h00; msg_valid = 1'b1; cipher_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("exp_data", b_cipher, exp_ex[i]);
    end
    check("exp_not_yet", b_expired, 1'b0);
    check("exp_drain_ready", b_ready, 1'b0);
    tick();
    check("exp_pulse", b_expired, 1'b1);
    check("exp_unloaded", b_loaded, 1'b0);
    check("exp_vld_clr", b_vld, 1'b0);
    tick();
    check("exp_pulse_end", b_expired, 1'b0);
    check("exp_no_fifth", b_vld, 1'b0);
    check("exp_idle_ready", b_ready, 1'b0);
    msg_valid = 1'b0;

    // Refresh colliding with an accept
    do_reset();
    load_key(8'hA5);
    msg = 8'h00; msg_valid = 1'b1; cipher_ready = 1'b1;
    tick();
    check("ref_c0", a_cipher, 8'hA5);
    tick();
    check("ref_c1", a_cipher, 8'h4B);
    key_in = 8'hFF; assembled = 1'b1;
    tick();
    assembled = 1'b0;
    check("ref_old_key", a_cipher, 8'h96);
    tick();
    check("ref_new_key", a_cipher, 8'hFF);
    repeat (14) tick();
    check("ref_count_restart", a_loaded, 1'b1);
    check("ref_c15", a_cipher, 8'hFF);
    tick();
    check("ref_budget_spent", a_loaded, 1'b0);
    msg_valid = 1'b0;
    tick();
    check("ref_expired", a_expired, 1'b1);

    // Clear with pending ciphertext and a coincident accept
    do_reset();
    load_key(8'hA5);
    msg = 8'h11; msg_valid = 1'b1; cipher_ready = 1'b0;
    tick();
    check("clr_pending", a_vld, 1'b1);
    clear = 1'b1; cipher_ready = 1'b1;
    tick();
    clear = 1'b0; msg_valid = 1'b0;
    check("clr_vld", a_vld, 1'b0);
    check("clr_loaded", a_loaded, 1'b0);
    check("clr_no_expire", a_expired, 1'b0);
    tick();
    check("clr_no_expire2", a_expired, 1'b0);

    // Asynchronous reset mid-stream, then recovery
    do_reset();
    load_key(8'hA5);
    msg = 8'h3C; msg_valid = 1'b1; cipher_ready = 1'b1;
    tick();
    check("arst_pre", a_cipher, 8'h99);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", a_vld, 1'b0);
    check("arst_cipher", a_cipher, 8'h00);
    check("arst_loaded", a_loaded, 1'b0);
    check("arst_ready", a_ready, 1'b0);
    #1 rst = 1'b0;
    msg_valid = 1'b0;
    tick();
    check("arst_no_key", a_loaded, 1'b0);
    load_key(8'hA5);
    msg_valid = 1'b1;
    tick();
    check("arst_recover", a_cipher, 8'h99);
    msg_valid = 1'b0;

    // Static key build
    do_reset();
    load_key(8'h5A);
    msg = 8'hFF; msg_valid = 1'b1; cipher_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rot0_data", c_cipher, 8'hA5);
    end
    msg_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
